// File: rtl/vector_mem_sequencer.sv
// Strided multi-word load/store burst sequencer; the vector data memory's only master.
// Loads stream through one output register with ready/valid backpressure; stores pass straight to the write port.
module vector_mem_sequencer #(
  parameter int ADDRESS_WIDTH = 19,
  parameter int DATA_WIDTH    = 64,
  parameter int COUNT_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_base,
  input  logic [ADDRESS_WIDTH-1:0] req_stride,
  input  logic [COUNT_WIDTH-1:0]   req_count,
  input  logic [DATA_WIDTH-1:0]    st_data,
  input  logic                     st_valid,
  output logic                     st_ready,
  output logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_valid,
  input  logic                     ld_ready,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] mem_readAddress,
  output logic [ADDRESS_WIDTH-1:0] mem_writeAddress,
  output logic                     mem_writeEnable,
  output logic [DATA_WIDTH-1:0]    mem_inputData,
  input  logic [DATA_WIDTH-1:0]    mem_outputData
);

  // state | meaning
  // IDLE  | waiting for a request; req_ready high
  // LOAD  | one read beat whenever the output register is empty or being taken
  // STORE | one memory write per cycle with st_valid high
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [ADDRESS_WIDTH-1:0] cur_addr_next;
  logic [ADDRESS_WIDTH-1:0] stride_r;
  logic [ADDRESS_WIDTH-1:0] stride_next;
  logic [COUNT_WIDTH-1:0]   remaining;
  logic [COUNT_WIDTH-1:0]   remaining_next;
  logic                     ld_beat;
  logic                     st_beat;

  always_comb begin
    state_next     = state;
    cur_addr_next  = cur_addr;
    stride_next    = stride_r;
    remaining_next = remaining;
    req_ready      = 1'b0;
    st_ready       = 1'b0;
    ld_beat        = 1'b0;
    st_beat        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cur_addr_next  = req_base;
          stride_next    = req_stride;
          remaining_next = req_count;
          if (req_count == '0) begin
            state_next = DONE;
          end else if (req_write) begin
            state_next = STORE;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        ld_beat = !ld_valid || ld_ready;
        if (ld_beat) begin
          cur_addr_next  = cur_addr + stride_r;
          remaining_next = remaining - COUNT_WIDTH'(1);
          if (remaining == COUNT_WIDTH'(1)) begin
            state_next = DONE;
          end
        end
      end
      STORE: begin
        // Gated by reset so an aborting edge cannot commit one more word.
        st_ready = !reset;
        st_beat  = st_valid && !reset;
        if (st_beat) begin
          cur_addr_next  = cur_addr + stride_r;
          remaining_next = remaining - COUNT_WIDTH'(1);
          if (remaining == COUNT_WIDTH'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      stride_r  <= '0;
      remaining <= '0;
      ld_data   <= '0;
      ld_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      cur_addr  <= cur_addr_next;
      stride_r  <= stride_next;
      remaining <= remaining_next;
      done      <= (state_next == DONE);
      // A word left over from the previous burst drains here even outside LOAD.
      if (ld_beat) begin
        ld_data  <= mem_outputData;
        ld_valid <= 1'b1;
      end else if (ld_ready) begin
        ld_valid <= 1'b0;
      end
    end
  end

  assign mem_readAddress  = cur_addr;
  assign mem_writeAddress = cur_addr;
  assign mem_inputData    = st_data;
  assign mem_writeEnable  = st_beat;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: directed boundary cases then random bursts
// checked against an address-list model (addr_k = base + k*stride mod 2**19).
module tb_vector_mem_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [18:0] req_base;
  logic [18:0] req_stride;
  logic [3:0]  req_count;
  logic [63:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] ld_data;
  logic        ld_valid;
  logic        ld_ready;
  logic        done;
  logic [18:0] mem_readAddress;
  logic [18:0] mem_writeAddress;
  logic        mem_writeEnable;
  logic [63:0] mem_inputData;
  logic [63:0] mem_outputData;
  logic [44:0] salt;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [63:0] rx_q[$];
  logic [18:0] wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  int          done_total = 0;

  bit          t2_vld [1:6] = '{1, 0, 1, 1, 1, 1};
  bit          t2_we  [1:6] = '{1, 0, 1, 1, 0, 0};
  logic [18:0] t2_adr [1:6] = '{19'h20, 19'h0, 19'h22, 19'h24, 19'h0, 19'h0};
  logic [63:0] t2_dat [1:6] = '{64'hAAAA_0000_1111_000A, 64'hDEAD_BEEF_DEAD_BEEF,
                                64'hBBBB_0000_2222_000B, 64'hCCCC_0000_3333_000C,
                                64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321};

  vector_mem_sequencer #(
    .ADDRESS_WIDTH(19),
    .DATA_WIDTH   (64),
    .COUNT_WIDTH  (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_base        (req_base),
    .req_stride      (req_stride),
    .req_count       (req_count),
    .st_data         (st_data),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .ld_data         (ld_data),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .done            (done),
    .mem_readAddress (mem_readAddress),
    .mem_writeAddress(mem_writeAddress),
    .mem_writeEnable (mem_writeEnable),
    .mem_inputData   (mem_inputData),
    .mem_outputData  (mem_outputData)
  );

  // Memory content is a pure function of address, so every load word names its address.
  assign mem_outputData = {salt, mem_readAddress};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_valid && ld_ready) rx_q.push_back(ld_data);
    if (mem_writeEnable) begin
      wr_addr_q.push_back(mem_writeAddress);
      wr_data_q.push_back(mem_inputData);
    end
    if (done) done_total++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run_burst(input logic w, input logic [18:0] base, input logic [18:0] stride,
                           input logic [3:0] cnt, input int rdy_pct, input int vld_pct);
    logic [18:0] exp_addr[$];
    logic [63:0] st_words[$];
    int          cyc;
    int          rx0;
    int          wr0;
    int          dn0;
    int          idx;
    bit          finished;
    bit          hold;
    logic [63:0] held;
    for (int k = 0; k < int'(cnt); k++) begin
      exp_addr.push_back(base + stride * 19'(k));
      st_words.push_back({$urandom(), $urandom()});
    end
    @(negedge clk);
    salt = 45'({$urandom(), $urandom()});
    rx0 = rx_q.size();
    wr0 = wr_addr_q.size();
    dn0 = done_total;
    req_valid = 1'b1;
    req_write = w;
    req_base = base;
    req_stride = stride;
    req_count = cnt;
    #1;
    chk("rb_req_ready", req_ready, 1);
    cyc = 0;
    finished = 1'b0;
    hold = 1'b0;
    held = '0;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      req_valid = 1'b0;
      ld_ready = (int'($urandom_range(99)) < rdy_pct);
      st_valid = (int'($urandom_range(99)) < vld_pct);
      idx = wr_addr_q.size() - wr0;
      st_data = (idx < int'(cnt)) ? st_words[idx] : {$urandom(), $urandom()};
      #1;
      if (hold) begin
        chk("rb_hold_valid", ld_valid, 1);
        chk("rb_hold_data", ld_data, held);
      end
      hold = ld_valid && !ld_ready;
      held = ld_data;
      finished = (done_total > dn0) && req_ready && !ld_valid;
      cyc++;
    end
    chk("rb_finished", finished, 1);
    chk("rb_done_count", done_total - dn0, 1);
    chk("rb_rx_count", rx_q.size() - rx0, w ? 0 : int'(cnt));
    chk("rb_wr_count", wr_addr_q.size() - wr0, w ? int'(cnt) : 0);
    if (!w) begin
      for (int k = 0; k < int'(cnt) && (rx0 + k) < rx_q.size(); k++)
        chk("rb_ld_word", rx_q[rx0 + k], {salt, exp_addr[k]});
    end else begin
      for (int k = 0; k < int'(cnt) && (wr0 + k) < wr_addr_q.size(); k++) begin
        chk("rb_wr_addr", wr_addr_q[wr0 + k], exp_addr[k]);
        chk("rb_wr_data", wr_data_q[wr0 + k], st_words[k]);
      end
    end
    st_valid = 1'b0;
  endtask

  initial begin
    int wr0;
    int dn0;
    logic [18:0] rb;
    logic [18:0] rs;
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_base = '0;
    req_stride = '0;
    req_count = '0;
    st_data = '0;
    st_valid = 1'b0;
    ld_ready = 1'b0;
    salt = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_st_ready", st_ready, 0);
    chk("rst_we", mem_writeEnable, 0);
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr", mem_readAddress, 0);

    // Unit-stride load with a consumer that is always ready.
    ld_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_base = 19'h10; req_stride = 19'h1; req_count = 4'd4;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("t1_valid", ld_valid, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) chk("t1_data", ld_data, 64'h10 + 64'(c - 2));
      chk("t1_done", done, (c == 5));
    end

    // Store with a one-cycle st_valid gap; st_valid stays high after the burst.
    wr0 = wr_addr_q.size();
    dn0 = done_total;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_base = 19'h20; req_stride = 19'h2; req_count = 4'd3;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      st_valid = t2_vld[c];
      st_data = t2_dat[c];
      #1;
      chk("t2_we", mem_writeEnable, t2_we[c]);
      if (t2_we[c]) begin
        chk("t2_waddr", mem_writeAddress, t2_adr[c]);
        chk("t2_wdata", mem_inputData, t2_dat[c]);
      end
      chk("t2_done", done, (c == 5));
    end
    st_valid = 1'b0;
    chk("t2_wr_count", wr_addr_q.size() - wr0, 3);
    chk("t2_done_count", done_total - dn0, 1);

    // Load stalled by the consumer for three cycles after the first word.
    salt = 45'($urandom());
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_base = 19'h40; req_stride = 19'h1; req_count = 4'd2;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      ld_ready = !(c >= 2 && c <= 4);
      #1;
      chk("t3_valid", ld_valid, (c >= 2 && c <= 6));
      if (c >= 2 && c <= 5) chk("t3_data_held", ld_data, {salt, 19'h40});
      if (c >= 2 && c <= 4) chk("t3_raddr_held", mem_readAddress, 19'h41);
      if (c == 6) chk("t3_data2", ld_data, {salt, 19'h41});
      chk("t3_done", done, (c == 6));
    end

    // Zero-count request: immediate done, no memory write even with st_valid high.
    wr0 = wr_addr_q.size();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_base = 19'h33; req_stride = 19'h1; req_count = 4'd0;
    st_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("t4_done", done, 1);
    chk("t4_we", mem_writeEnable, 0);
    chk("t4_st_ready", st_ready, 0);
    chk("t4_req_ready", req_ready, 0);
    @(negedge clk);
    #1;
    chk("t4_done_low", done, 0);
    chk("t4_req_ready_back", req_ready, 1);
    chk("t4_wr_count", wr_addr_q.size() - wr0, 0);
    st_valid = 1'b0;

    // Address wrap upward and descending stride.
    run_burst(1'b0, 19'h7FFFF, 19'h00001, 4'd2, 100, 100);
    run_burst(1'b1, 19'h00005, 19'h7FFFF, 4'd3, 100, 100);

    // Reset after two of five store words.
    wr0 = wr_addr_q.size();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_base = 19'h100; req_stride = 19'h1; req_count = 4'd5;
    st_valid = 1'b1;
    st_data = 64'h5555_0000_0000_0000;
    @(negedge clk);
    req_valid = 1'b0;
    st_data = 64'h5555_0000_0000_0001;
    @(negedge clk);
    st_data = 64'h5555_0000_0000_0002;
    @(negedge clk);
    reset = 1'b1;
    st_data = 64'h5555_0000_0000_0003;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_req_ready", req_ready, 1);
    chk("t5_done", done, 0);
    chk("t5_ld_valid", ld_valid, 0);
    chk("t5_raddr", mem_readAddress, 0);
    chk("t5_wr_count", wr_addr_q.size() - wr0, 2);
    if (wr_addr_q.size() - wr0 >= 2) begin
      chk("t5_wr_addr1", wr_addr_q[wr0 + 1], 19'h101);
      chk("t5_wr_data1", wr_data_q[wr0 + 1], 64'h5555_0000_0000_0002);
    end
    @(negedge clk);
    #1;
    chk("t5_we_idle", mem_writeEnable, 0);
    chk("t5_wr_count_after", wr_addr_q.size() - wr0, 2);
    st_valid = 1'b0;

    // Random bursts: random direction, base, stride class, count and handshake rates.
    for (int n = 0; n < 40; n++) begin
      rb = 19'($urandom());
      case ($urandom_range(3))
        0: rs = 19'h0;
        1: rs = 19'($urandom_range(1, 4));
        2: rs = 19'h0 - 19'($urandom_range(1, 4));
        default: rs = 19'($urandom());
      endcase
      run_burst(1'($urandom_range(1)), rb, rs, 4'($urandom_range(15)),
                (n % 3 == 0) ? 100 : int'($urandom_range(20, 90)),
                (n % 4 == 0) ? 100 : int'($urandom_range(20, 90)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
